// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline-boundary register for the 5-stage hart (IF/ID, ID/EX,
//   EX/MEM, MEM/WB). Carries a payload and a control field through a
//   valid/ready handshake. Supports flush, bubble injection and an optional
//   2-entry skid buffer.
//
//   Build option:
//     PIPE_STAGE_SKID_EN defined   : main register M plus skid register S.
//                                    o_ready is a pure register output.
//                                    o_count is 0..2.
//     PIPE_STAGE_SKID_EN undefined : M only.
//                                    o_ready = !M.valid || i_ready.
//                                    o_count is 0..1.
//
//   Ports:
//     i_clk, i_rst_n        clock; synchronous active-low reset
//     i_flush               drop held entries and any beat offered this cycle
//     i_valid/o_ready       upstream handshake
//     i_bubble              store the upstream beat as a NOP
//     i_data, i_ctrl        upstream payload and control field
//     o_valid/i_ready       downstream handshake
//     o_data, o_ctrl        head payload and control field (registered)
//     o_live                head is a real instruction (0 = bubble/NOP)
//     o_count               number of entries held
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_bubble,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_live,
  output logic [1:0]        o_count
);

  logic              acc;
  logic              pop;
  logic [CTRL_W-1:0] beat_ctrl;
  logic              beat_live;

  // Main (head) register.
  logic              m_vld_q,  m_vld_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic              m_live_q, m_live_d;

  // A bubble keeps its payload but loses its control effects.
  assign beat_ctrl = i_bubble ? CTRL_NOP : i_ctrl;
  assign beat_live = !i_bubble;

  assign acc = i_valid && o_ready;
  assign pop = m_vld_q && i_ready;

  assign o_valid = m_vld_q;
  assign o_data  = m_data_q;
  assign o_ctrl  = m_ctrl_q;
  assign o_live  = m_live_q;

`ifdef PIPE_STAGE_SKID_EN
  // Skid register: only ever valid while M is valid.
  logic              s_vld_q,  s_vld_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              s_live_q, s_live_d;

  // Ready depends only on state, which breaks the i_ready -> o_ready path.
  assign o_ready = !s_vld_q;
  assign o_count = {1'b0, m_vld_q} + {1'b0, s_vld_q};

  always_comb begin
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    m_live_d = m_live_q;
    s_vld_d  = s_vld_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    s_live_d = s_live_q;
    if (s_vld_q) begin
      // Full: no accept is possible; a pop promotes S into M.
      if (pop) begin
        m_vld_d  = 1'b1;
        m_data_d = s_data_q;
        m_ctrl_d = s_ctrl_q;
        m_live_d = s_live_q;
        s_vld_d  = 1'b0;
      end
    end else if (acc && (!m_vld_q || pop)) begin
      m_vld_d  = 1'b1;
      m_data_d = i_data;
      m_ctrl_d = beat_ctrl;
      m_live_d = beat_live;
    end else if (acc) begin
      // Head stalled: park the beat in the skid slot.
      s_vld_d  = 1'b1;
      s_data_d = i_data;
      s_ctrl_d = beat_ctrl;
      s_live_d = beat_live;
    end else if (pop) begin
      m_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_ctrl_q <= CTRL_NOP;
      m_live_q <= 1'b0;
      s_vld_q  <= 1'b0;
      s_data_q <= '0;
      s_ctrl_q <= CTRL_NOP;
      s_live_q <= 1'b0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      m_live_q <= m_live_d;
      s_vld_q  <= s_vld_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_live_q <= s_live_d;
    end
  end
`else
  // Single entry: can refill in the same cycle the head leaves.
  assign o_ready = !m_vld_q || i_ready;
  assign o_count = {1'b0, m_vld_q};

  always_comb begin
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    m_live_d = m_live_q;
    if (acc) begin
      m_vld_d  = 1'b1;
      m_data_d = i_data;
      m_ctrl_d = beat_ctrl;
      m_live_d = beat_live;
    end else if (pop) begin
      m_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_ctrl_q <= CTRL_NOP;
      m_live_q <= 1'b0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      m_live_q <= m_live_d;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-boundary register for the 5-stage hart. It is the successor to the fixed per-stage register banks.
- Carries a generic payload plus a control field through a valid/ready handshake, with flush, bubble injection and an optional 2-entry skid buffer.
- Instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB, so that stalls propagate by back-pressure rather than by ad-hoc hold muxes.

Parameters:
- DATA_W, 32: payload width; preserved on bubble, zeroed on flush/reset.
- CTRL_W, 8: control-field width (reg_write, mem_read, …); forced to CTRL_NOP on bubble, flush and reset.
- CTRL_NOP, 0: CTRL_W-bit value representing a NOP's control field.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_flush  in  1  discard all held entries and any beat offered this cycle.
- i_valid  in  1  upstream beat present.
- o_ready  out  1  stage can accept a beat this cycle.
- i_bubble  in  1  qualifies the upstream beat: store it as a NOP.
- i_data  in  DATA_W  upstream payload.
- i_ctrl  in  CTRL_W  upstream control field.
- o_valid  out  1  beat presented downstream.
- i_ready  in  1  downstream accepts the beat.
- o_data  out  DATA_W  head payload.
- o_ctrl  out  CTRL_W  head control field.
- o_live  out  1  head is a real instruction (0 = bubble/NOP); drives the retire valid.
- o_count  out  2  entries held, 0..2.

Behaviour:
- Transfers:
  - Upstream transfer (acc) = i_valid && o_ready.
  - Downstream transfer (pop) = o_valid && i_ready.
  - Entries are held in order: main register M (the head) and skid register S.
- Storage:
  - Each entry holds data, ctrl, live and a valid bit.
  - An accepted beat stores {i_data, i_bubble ? CTRL_NOP : i_ctrl, !i_bubble}.
  - Outputs o_data, o_ctrl and o_live come directly from M (registered).
  - o_valid = M.valid.
- Reset (i_rst_n=0 at edge):
  - M and S cleared: valid=0, data=0, ctrl=CTRL_NOP, live=0.
  - After reset: o_valid=0, o_count=0, o_ready=1.
  - A reset mid-transfer discards everything; it has priority over flush.
- Flush (i_flush=1 at edge, not in reset):
  - Same clearing as reset.
  - A beat offered in the same cycle is dropped. o_ready is not forced low, so upstream drains.
  - A pop in the same cycle is still visible downstream; the entry is then gone.
- Normal update with skid, S empty:
  - acc && (!M.valid || pop): M <= beat.
  - acc && M.valid && !pop: S <= beat (this is the skid capture).
  - !acc && pop: M.valid <= 0.
- Normal update with skid, S valid (no acc possible):
  - pop: M <= S, S.valid <= 0.
  - Otherwise hold.
- o_ready (skid build) = !S.valid, a pure register output with no combinational path from i_ready.
- Latency and throughput:
  - Latency 1 cycle from acc to o_valid.
  - Full throughput 1 beat/cycle when i_ready stays high.
  - Order preserved, no beat duplicated or lost except on flush/reset.
- o_count = M.valid + S.valid. An invariant holds: S.valid implies M.valid.
- Held outputs (o_valid && !i_ready) must stay bit-stable until pop.

Optional Feature:
- Macro PIPE_STAGE_SKID_EN.
- Defined: the 2-entry skid behaviour above; o_ready is registered; o_count ranges 0..2.
- Undefined:
  - S is not built.
  - o_ready = !M.valid || i_ready (combinational).
  - acc loads M; pop without acc clears M.valid.
  - o_count ranges 0..1; bit 1 is tied 0.
  - Reset, flush and bubble rules are unchanged.

Test Plan:
- Reset then stream: hold i_rst_n=0 for 2 cycles, then send i_data=0x11,0x22,0x33 (i_ctrl=0x5A) with i_ready=1 -> o_valid for 3 consecutive cycles starting 1 cycle after the first beat, data 0x11,0x22,0x33, o_ctrl=0x5A, o_live=1, o_count=1.
- Back-pressure/skid (SKID_EN): with M=0xA0, drop i_ready and offer 0xB0 -> S captures it, o_count=2, o_ready=0. Raise i_ready -> 0xA0 then 0xB0 pop in order, o_ready returns to 1 one cycle after S drains. No-skid build: 0xB0 stalls upstream, o_count≤1.
- Bubble: beat 0xDEAD with i_ctrl=0xFF and i_bubble=1 -> o_data=0xDEAD, o_ctrl=CTRL_NOP (0x00), o_live=0, o_valid=1.
- Flush while full: o_count=2, assert i_flush with i_valid=1 (data 0x77) -> next cycle o_valid=0, o_count=0, o_ctrl=0x00; 0x77 is never emitted.
- Reset vs flush: i_rst_n=0 and i_flush=1 together with o_count=2 -> all outputs at reset values. A subsequent beat 0x01 appears normally 1 cycle after acceptance.
- Hold stability: o_valid=1 with i_ready=0 for 5 cycles while the upstream offers new beats -> o_data/o_ctrl/o_live unchanged each cycle; no beat lost.
